// File: rtl/msg_pkg.sv
// rtl/msg_pkg.sv - shared constants and state encoding for the message loader
package msg_pkg;

    localparam int DEPTH  = 16;
    localparam int DATA_W = 16;
    localparam int ADDR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_FILL   = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

endpackage

// File: rtl/msg_loader_if.sv
// rtl/msg_loader_if.sv - display memory port-A write bundle
interface msg_loader_if #(
    parameter int ADDR_W = msg_pkg::ADDR_W,
    parameter int DATA_W = msg_pkg::DATA_W
);

    logic              ena;
    logic              wea;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dina;

    modport master (output ena, output wea, output addra, output dina);
    modport slave  (input  ena, input  wea, input  addra, input  dina);

endinterface

// File: rtl/msg_loader.sv
// rtl/msg_loader.sv - write-side driver of the scrolling display message memory
module msg_loader #(
    parameter int DEPTH  = msg_pkg::DEPTH,
    parameter int DATA_W = msg_pkg::DATA_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_W-1:0]       sw,
    input  logic                    wr_btn,
    input  logic                    done_btn,
    input  logic                    clear_btn,
    output logic [$clog2(DEPTH):0]  msg_len,
    output logic                    msg_valid,
    output logic                    full,
    output logic                    busy,
    msg_loader_if.master            mem
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int LEN_W  = ADDR_W + 1;
    localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    import msg_pkg::*;

    state_e              state_q,   state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [LEN_W-1:0]    len_q,     len_d;
    logic                wr_q,      wr_d;
    logic [ADDR_W-1:0]   addra_q,   addra_d;
    logic [DATA_W-1:0]   dina_q,    dina_d;
    logic                valid_q,   valid_d;
    logic                full_q,    full_d;
    logic                busy_q,    busy_d;

    // Next-state: clear sweep, message append/commit, clear_btn overrides everything
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        len_d     = len_q;
        wr_d      = 1'b0;
        addra_d   = addra_q;
        dina_d    = dina_q;
        valid_d   = valid_q;
        busy_d    = 1'b0;

        if (clear_btn) begin
            // Same starting point as reset: the sweep begins on the following cycle
            state_d   = ST_CLEAR;
            clr_cnt_d = '0;
            len_d     = '0;
            valid_d   = 1'b0;
            busy_d    = 1'b1;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    wr_d      = 1'b1;
                    addra_d   = clr_cnt_q;
                    dina_d    = '0;
                    busy_d    = 1'b1;
                    clr_cnt_d = clr_cnt_q + 1'b1;
                    if (clr_cnt_q == ADDR_LAST) begin
                        state_d = ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (wr_btn && (len_q != LEN_MAX)) begin
                        wr_d    = 1'b1;
                        addra_d = len_q[ADDR_W-1:0];
                        dina_d  = sw;
                        len_d   = len_q + 1'b1;
                    end
                    // Uses the post-write length so a same-cycle write can make the commit legal
                    if (done_btn && (len_d != '0)) begin
                        state_d = ST_COMMIT;
                        valid_d = 1'b1;
                    end
                end
                ST_COMMIT: begin
                    valid_d = 1'b1;
                end
                default: begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                    busy_d    = 1'b1;
                end
            endcase
        end

        full_d = (len_d == LEN_MAX);
    end

    // State and registered outputs, reset has top priority
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            len_q     <= '0;
            wr_q      <= 1'b0;
            addra_q   <= '0;
            dina_q    <= '0;
            valid_q   <= 1'b0;
            full_q    <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            len_q     <= len_d;
            wr_q      <= wr_d;
            addra_q   <= addra_d;
            dina_q    <= dina_d;
            valid_q   <= valid_d;
            full_q    <= full_d;
            busy_q    <= busy_d;
        end
    end

    assign mem.ena   = wr_q;
    assign mem.wea   = wr_q;
    assign mem.addra = addra_q;
    assign mem.dina  = dina_q;
    assign msg_len   = len_q;
    assign msg_valid = valid_q;
    assign full      = full_q;
    assign busy      = busy_q;

endmodule

// File: doc/msg_loader.md
MSG_LOADER -- requirements
Module: msg_loader

Interface
REQ-001 Parameter DEPTH, default 16, number of 16-bit message words in the display memory (power of two).
REQ-002 Parameter DATA_W, default 16, memory word width.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 sw  input  DATA_W  switch word to be written.
REQ-006 wr_btn  input  1  single-cycle pulse: append sw as next word.
REQ-007 done_btn  input  1  single-cycle pulse: commit message.
REQ-008 clear_btn  input  1  single-cycle pulse: erase memory and message.
REQ-009 ena  output  1  memory port-A enable.
REQ-010 wea  output  1  memory port-A write enable.
REQ-011 addra  output  log2(DEPTH)  memory port-A address.
REQ-012 dina  output  DATA_W  memory port-A write data.
REQ-013 msg_len  output  log2(DEPTH)+1  number of words written, 0..DEPTH.
REQ-014 msg_valid  output  1  high while a committed message is available to the display reader.
REQ-015 full  output  1  high when msg_len == DEPTH.
REQ-016 busy  output  1  high while memory clear is in progress.

Function
REQ-017 The block SHALL be the write-side driver of the display memory whose read side scrolls words onto the 7-segment display.
REQ-018 FSM states SHALL be CLEAR, FILL, COMMIT.
REQ-019 CLEAR: one write per cycle, ena=wea=1, dina=0, addra=0..DEPTH-1 ascending; cycle after addra=DEPTH-1 is written, state->FILL, wea=ena=0, busy=0.
REQ-020 CLEAR SHALL ignore wr_btn and done_btn; clear_btn in CLEAR restarts the sweep at addra=0.
REQ-021 FILL: wr_btn with msg_len<DEPTH SHALL produce, on the next cycle, ena=wea=1, addra=msg_len (pre-increment), dina=sw sampled at the pulse; msg_len increments in that same cycle.
REQ-022 FILL: wr_btn with msg_len==DEPTH SHALL be ignored (no write, msg_len unchanged).
REQ-023 FILL: done_btn with msg_len>0 SHALL move to COMMIT next cycle and assert msg_valid; done_btn with msg_len==0 SHALL be ignored.
REQ-024 FILL: wr_btn and done_btn in the same cycle SHALL perform the write and commit, msg_len including the new word.
REQ-025 COMMIT: wr_btn and done_btn ignored; msg_valid held high, msg_len held.
REQ-026 clear_btn in FILL or COMMIT SHALL enter CLEAR next cycle, msg_len=0, msg_valid=0, full=0, busy=1; clear_btn wins over any simultaneous wr_btn/done_btn.
REQ-027 All outputs SHALL be registered; wea and ena SHALL be low in every cycle without a write.
REQ-028 full SHALL equal (msg_len==DEPTH) and update in the same cycle as msg_len.

Reset
REQ-029 reset SHALL take priority over all inputs and, on the next edge, set state=CLEAR, clear counter=0, ena=wea=0, addra=0, dina=0, msg_len=0, msg_valid=0, full=0, busy=1.
REQ-030 The first clear write (addra=0) SHALL appear the first cycle after reset deasserts; reset mid-sweep or mid-fill restarts from this state.

Structure
REQ-031 State enum and constants DEPTH, DATA_W, ADDR_W SHALL live in shared package msg_pkg.
REQ-032 No sub-module; clear address and write pointer counters are inline.

Verification
REQ-033 Reset 1 cycle, release -> wea=1 for exactly 16 cycles, addra 0..15, dina=0; then busy=0, state FILL.
REQ-034 wr_btn with sw=16'h4321, then sw=16'hBEEF -> writes addr0=4321, addr1=BEEF one cycle after each pulse; msg_len=2.
REQ-035 17 wr_btn pulses -> 16 writes, full=1 after 16th, 17th produces no wea, msg_len=16.
REQ-036 done_btn with msg_len=0 -> no change; wr_btn+done_btn same cycle (sw=16'h00A5) -> write addr0, msg_valid=1, msg_len=1.
REQ-037 In COMMIT, wr_btn -> no wea; clear_btn with simultaneous wr_btn -> CLEAR, msg_valid=0, 16 zero writes.
REQ-038 reset asserted at clear addra=7 -> sweep restarts at addra=0 after release.
